// File: rtl/uart_bridge_pkg.sv
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Shared types and constants for the UART register bridge.
//               The GET_CSUM state exists only when UART_REG_BRIDGE_CSUM_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_bridge_pkg;

    // Bridge FSM states; the encoding is fixed at 3 bits
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        BUS_WR   = 3'd3,
        BUS_RD   = 3'd4,
        RD_WAIT  = 3'd5,
`ifdef UART_REG_BRIDGE_CSUM_EN
        SEND     = 3'd6,
        GET_CSUM = 3'd7
`else
        SEND     = 3'd6
`endif
    } state_t;

    // Host command bytes and the checksum-failure response
    localparam logic [7:0] CMD_WR        = 8'h57;
    localparam logic [7:0] CMD_RD        = 8'h52;
    localparam logic [7:0] CSUM_ERR_BYTE = 8'h45;

endpackage

`default_nettype wire

// File: rtl/uart_bridge_timeout.sv
// ============================================================================
// Module      : uart_bridge_timeout
// Description : Inter-byte timeout counter. Counts while run is high, returns
//               to zero on clr or when not running, and raises expire in the
//               cycle the count sits at TIMEOUT_CLKS-1 with no clr present.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bridge_timeout #(
    parameter int TIMEOUT_CLKS = 2604000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int              CW     = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] r_cnt;

    // Count clocks spent waiting for the next byte of a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || !run || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // An arriving byte (clr) always beats a coincident expiry
    assign expire = run && !clr && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_reg_bridge.sv
// ============================================================================
// Module      : uart_reg_bridge
// Description : UART byte-stream command responder. Parses 'W' addr data and
//               'R' addr frames, performs one register bus access, and returns
//               a single response byte through the UART transmitter.
//               Optional macro UART_REG_BRIDGE_CSUM_EN adds a trailing XOR
//               checksum byte to W/R frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 2604000,
    parameter logic [7:0] ACK_BYTE     = 8'h4B,
    parameter logic [7:0] NAK_BYTE     = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err
);

    state_t     r_state, w_state_nx;
    logic       r_is_wr, w_is_wr_nx;
    logic [7:0] w_tx_nx, w_addr_nx, w_wdata_nx;
    logic       w_run, w_expire;
`ifdef UART_REG_BRIDGE_CSUM_EN
    logic [7:0] r_csum, w_csum_nx;
`endif

    // Timer runs only while a frame is partially received
`ifdef UART_REG_BRIDGE_CSUM_EN
    assign w_run = (r_state == GET_ADDR) || (r_state == GET_DATA) || (r_state == GET_CSUM);
`else
    assign w_run = (r_state == GET_ADDR) || (r_state == GET_DATA);
`endif

    uart_bridge_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (w_run),
        .clr    (rx_done),
        .expire (w_expire)
    );

    assign busy = (r_state != IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Frame fields and response byte registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_wr   <= 1'b0;
            tx_data   <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
`ifdef UART_REG_BRIDGE_CSUM_EN
            r_csum    <= 8'h00;
`endif
        end else begin
            r_is_wr   <= w_is_wr_nx;
            tx_data   <= w_tx_nx;
            reg_addr  <= w_addr_nx;
            reg_wdata <= w_wdata_nx;
`ifdef UART_REG_BRIDGE_CSUM_EN
            r_csum    <= w_csum_nx;
`endif
        end
    end

    // Next-state, strobes and datapath updates
    always_comb begin
        w_state_nx = r_state;
        w_is_wr_nx = r_is_wr;
        w_tx_nx    = tx_data;
        w_addr_nx  = reg_addr;
        w_wdata_nx = reg_wdata;
`ifdef UART_REG_BRIDGE_CSUM_EN
        w_csum_nx  = r_csum;
`endif
        reg_we     = 1'b0;
        reg_re     = 1'b0;
        tx_start   = 1'b0;
        frame_err  = 1'b0;

        case (r_state)
            IDLE: begin
                if (rx_done) begin
`ifdef UART_REG_BRIDGE_CSUM_EN
                    w_csum_nx = rx_data;
`endif
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        w_is_wr_nx = (rx_data == CMD_WR);
                        w_state_nx = GET_ADDR;
                    end else begin
                        w_tx_nx    = NAK_BYTE;
                        w_state_nx = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_done) begin
                    w_addr_nx = rx_data;
`ifdef UART_REG_BRIDGE_CSUM_EN
                    w_csum_nx  = r_csum ^ rx_data;
                    w_state_nx = r_is_wr ? GET_DATA : GET_CSUM;
`else
                    w_state_nx = r_is_wr ? GET_DATA : BUS_RD;
`endif
                end else if (w_expire) begin
                    frame_err  = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_done) begin
                    w_wdata_nx = rx_data;
`ifdef UART_REG_BRIDGE_CSUM_EN
                    w_csum_nx  = r_csum ^ rx_data;
                    w_state_nx = GET_CSUM;
`else
                    w_state_nx = BUS_WR;
`endif
                end else if (w_expire) begin
                    frame_err  = 1'b1;
                    w_state_nx = IDLE;
                end
            end
`ifdef UART_REG_BRIDGE_CSUM_EN
            GET_CSUM: begin
                if (rx_done) begin
                    if (rx_data == r_csum) begin
                        w_state_nx = r_is_wr ? BUS_WR : BUS_RD;
                    end else begin
                        frame_err  = 1'b1;
                        w_tx_nx    = CSUM_ERR_BYTE;
                        w_state_nx = SEND;
                    end
                end else if (w_expire) begin
                    frame_err  = 1'b1;
                    w_state_nx = IDLE;
                end
            end
`endif
            BUS_WR: begin
                reg_we     = 1'b1;
                frame_err  = rx_done;
                w_tx_nx    = ACK_BYTE;
                w_state_nx = SEND;
            end
            BUS_RD: begin
                reg_re     = 1'b1;
                frame_err  = rx_done;
                w_state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                frame_err  = rx_done;
                w_tx_nx    = reg_rdata;
                w_state_nx = SEND;
            end
            SEND: begin
                // The UART raises tx_busy the cycle after tx_start
                frame_err = rx_done;
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
// ============================================================================
// Module      : tb_uart_reg_bridge
// Description : Directed self-checking bench for uart_reg_bridge. Frames gain
//               a trailing XOR checksum when UART_REG_BRIDGE_CSUM_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_reg_bridge;

    localparam int TIMEOUT_CLKS = 100;
    localparam int GAP          = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] reg_rdata = 8'h00;
    logic [7:0] tx_data, reg_addr, reg_wdata;
    logic       tx_start, reg_we, reg_re, busy, frame_err;

    int pass  = 0;
    int total = 0;

    uart_reg_bridge #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: read data valid one cycle after reg_re
    always @(posedge clk) begin
        case (reg_addr)
            8'h22:   reg_rdata <= reg_re ? 8'h3C : 8'h00;
            8'h33:   reg_rdata <= reg_re ? 8'h77 : 8'h00;
            8'h10:   reg_rdata <= reg_re ? 8'h5A : 8'h00;
            default: reg_rdata <= reg_re ? 8'hEE : 8'h00;
        endcase
    end

    // Event monitor sampled on the falling edge
    int         we_cnt = 0, re_cnt = 0, ts_cnt = 0, fe_cnt = 0, viol = 0;
    int         we_cyc = 0, fe_cyc = 0;
    logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, ts_data = 0;
    logic       prev_ts = 1'b0, busy_after_ts = 1'b1;
    always @(negedge clk) begin
        if (prev_ts) busy_after_ts = busy;
        prev_ts = tx_start;
        if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; we_cyc = cyc; end
        if (reg_re) begin re_cnt++; re_addr = reg_addr; end
        if (tx_start) begin ts_cnt++; ts_data = tx_data; if (tx_busy) viol++; end
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int at);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        at      = cyc;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input int n, output int last);
        logic [7:0] x;
        int at;
        send_byte(b0, at);
        x = b0;
        tick(GAP);
        send_byte(b1, at);
        x ^= b1;
        if (n == 3) begin
            tick(GAP);
            send_byte(b2, at);
            x ^= b2;
        end
`ifdef UART_REG_BRIDGE_CSUM_EN
        tick(GAP);
        send_byte(x, at);
`endif
        last = at;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy && i < 2000) begin tick(1); i++; end
        total++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, need 0", name, busy, i);
        else pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        total++;
        if ({tx_data, reg_addr, reg_wdata, tx_start, reg_we, reg_re, busy, frame_err} !== 29'd0)
            $display("FAIL reset_outputs: got %h, need 0",
                     {tx_data, reg_addr, reg_wdata, tx_start, reg_we, reg_re, busy, frame_err});
        else pass++;
        tick(3);
        rst = 1'b0;
        tick(2);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, need 0", busy); else pass++;
    endtask

    task automatic test_write();
        int w0, t0, last;
        w0 = we_cnt; t0 = ts_cnt;
        send_frame(8'h57, 8'h10, 8'hA5, 3, last);
        wait_idle("write");
        total++; if (we_cnt - w0 !== 1) $display("FAIL wr_count: got %0d, need 1", we_cnt - w0); else pass++;
        total++; if (we_addr !== 8'h10) $display("FAIL wr_addr: got %h, need 10", we_addr); else pass++;
        total++; if (we_data !== 8'hA5) $display("FAIL wr_data: got %h, need a5", we_data); else pass++;
        total++; if (we_cyc - last !== 1) $display("FAIL wr_latency: got %0d, need 1", we_cyc - last); else pass++;
        total++; if (ts_cnt - t0 !== 1) $display("FAIL wr_txcount: got %0d, need 1", ts_cnt - t0); else pass++;
        total++; if (ts_data !== 8'h4B) $display("FAIL wr_ack: got %h, need 4b", ts_data); else pass++;
    endtask

    task automatic test_read();
        int r0, w0, last;
        r0 = re_cnt; w0 = we_cnt;
        send_frame(8'h52, 8'h22, 8'h00, 2, last);
        wait_idle("read");
        total++; if (re_cnt - r0 !== 1) $display("FAIL rd_count: got %0d, need 1", re_cnt - r0); else pass++;
        total++; if (re_addr !== 8'h22) $display("FAIL rd_addr: got %h, need 22", re_addr); else pass++;
        total++; if (ts_data !== 8'h3C) $display("FAIL rd_data: got %h, need 3c", ts_data); else pass++;
        total++; if (we_cnt !== w0) $display("FAIL rd_nowrite: got %0d writes, need 0", we_cnt - w0); else pass++;
    endtask

    task automatic test_nak();
        int r0, w0, t0, at;
        r0 = re_cnt; w0 = we_cnt; t0 = ts_cnt;
        send_byte(8'h7E, at);
        wait_idle("nak");
        tick(2);
        total++; if ((re_cnt - r0) + (we_cnt - w0) !== 0) $display("FAIL nak_bus: got %0d accesses, need 0", (re_cnt - r0) + (we_cnt - w0)); else pass++;
        total++; if (ts_cnt - t0 !== 1) $display("FAIL nak_txcount: got %0d, need 1", ts_cnt - t0); else pass++;
        total++; if (ts_data !== 8'h3F) $display("FAIL nak_byte: got %h, need 3f", ts_data); else pass++;
        total++; if (busy_after_ts !== 1'b0) $display("FAIL nak_busy_after: got %b, need 0", busy_after_ts); else pass++;
    endtask

    task automatic test_timeout();
        int f0, t0, w0, at;
        f0 = fe_cnt; t0 = ts_cnt; w0 = we_cnt;
        send_byte(8'h57, at);
        tick(TIMEOUT_CLKS + 20);
        total++; if (fe_cnt - f0 !== 1) $display("FAIL to_err_count: got %0d, need 1", fe_cnt - f0); else pass++;
        total++; if (fe_cyc - at !== TIMEOUT_CLKS) $display("FAIL to_latency: got %0d, need %0d", fe_cyc - at, TIMEOUT_CLKS); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL to_idle: busy=%b, need 0", busy); else pass++;
        total++; if ((ts_cnt - t0) + (we_cnt - w0) !== 0) $display("FAIL to_silent: got %0d events, need 0", (ts_cnt - t0) + (we_cnt - w0)); else pass++;
    endtask

    task automatic test_tx_busy();
        int f0, t0, r0, last, at;
        f0 = fe_cnt; t0 = ts_cnt; r0 = re_cnt;
        tx_busy = 1'b1;
        send_frame(8'h52, 8'h33, 8'h00, 2, last);
        tick(10);
        send_byte(8'h7E, at);
        tick(488);
        total++; if (fe_cnt - f0 !== 1) $display("FAIL busy_overrun_err: got %0d, need 1", fe_cnt - f0); else pass++;
        total++; if (ts_cnt !== t0) $display("FAIL busy_hold: got %0d tx_start, need 0", ts_cnt - t0); else pass++;
        total++; if (busy !== 1'b1) $display("FAIL busy_in_send: got %b, need 1", busy); else pass++;
        tx_busy = 1'b0;
        wait_idle("busy");
        tick(20);
        total++; if (ts_cnt - t0 !== 1) $display("FAIL busy_txcount: got %0d, need 1", ts_cnt - t0); else pass++;
        total++; if (ts_data !== 8'h77) $display("FAIL busy_rd_data: got %h, need 77", ts_data); else pass++;
        total++; if (re_cnt - r0 !== 1) $display("FAIL busy_rd_count: got %0d, need 1", re_cnt - r0); else pass++;
        total++; if (viol !== 0) $display("FAIL busy_start_while_busy: got %0d, need 0", viol); else pass++;
    endtask

    task automatic test_reset_mid();
        int w0, r0, t0, at, last;
        w0 = we_cnt;
        send_byte(8'h57, at);
        tick(GAP);
        send_byte(8'h10, at);
        tick(3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({tx_data, reg_addr, reg_wdata, tx_start, reg_we, reg_re, busy, frame_err} !== 29'd0)
            $display("FAIL midrst_outputs: got %h, need 0",
                     {tx_data, reg_addr, reg_wdata, tx_start, reg_we, reg_re, busy, frame_err});
        else pass++;
        tick(2);
        rst = 1'b0;
        tick(2);
        r0 = re_cnt; t0 = ts_cnt;
        send_frame(8'h52, 8'h10, 8'h00, 2, last);
        wait_idle("midrst");
        total++; if (re_cnt - r0 !== 1) $display("FAIL midrst_rd_count: got %0d, need 1", re_cnt - r0); else pass++;
        total++; if (re_addr !== 8'h10) $display("FAIL midrst_rd_addr: got %h, need 10", re_addr); else pass++;
        total++; if (ts_data !== 8'h5A) $display("FAIL midrst_rd_data: got %h, need 5a", ts_data); else pass++;
        total++; if (ts_cnt - t0 !== 1) $display("FAIL midrst_txcount: got %0d, need 1", ts_cnt - t0); else pass++;
        total++; if (we_cnt !== w0) $display("FAIL midrst_nowrite: got %0d, need 0", we_cnt - w0); else pass++;
    endtask

`ifdef UART_REG_BRIDGE_CSUM_EN
    task automatic test_csum();
        int w0, f0, at;
        w0 = we_cnt;
        send_byte(8'h57, at); tick(GAP);
        send_byte(8'h10, at); tick(GAP);
        send_byte(8'hA5, at); tick(GAP);
        send_byte(8'hE2, at);
        wait_idle("csum_ok");
        total++; if (we_cnt - w0 !== 1) $display("FAIL csum_ok_write: got %0d, need 1", we_cnt - w0); else pass++;
        total++; if (ts_data !== 8'h4B) $display("FAIL csum_ok_ack: got %h, need 4b", ts_data); else pass++;
        w0 = we_cnt; f0 = fe_cnt;
        send_byte(8'h57, at); tick(GAP);
        send_byte(8'h10, at); tick(GAP);
        send_byte(8'hA5, at); tick(GAP);
        send_byte(8'h00, at);
        wait_idle("csum_bad");
        total++; if (we_cnt !== w0) $display("FAIL csum_bad_write: got %0d, need 0", we_cnt - w0); else pass++;
        total++; if (ts_data !== 8'h45) $display("FAIL csum_bad_resp: got %h, need 45", ts_data); else pass++;
        total++; if (fe_cnt - f0 !== 1) $display("FAIL csum_bad_err: got %0d, need 1", fe_cnt - f0); else pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_timeout();
        test_tx_busy();
        test_reset_mid();
`ifdef UART_REG_BRIDGE_CSUM_EN
        test_csum();
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

`default_nettype wire
